// File: rtl/uart_tx_arbiter_if.sv
// Producer/uart-side bundle for uart_tx_arbiter: per-requester valid/ready/data plus the
// strobe, byte and status lines toward the shared uart transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_is_transmitting;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 start_err;

  modport master (
    output req_valid, req_data, uart_is_transmitting,
    input  req_ready, uart_transmit, uart_tx_byte, grant_id, busy, start_err
  );

  modport slave (
    input  req_valid, req_data, uart_is_transmitting,
    output req_ready, uart_transmit, uart_tx_byte, grant_id, busy, start_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_TAG_EN to precede each data byte with a {TAG_PREFIX, grant_id} tag frame.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 16,
  parameter logic [3:0]  TAG_PREFIX    = 4'hA
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned TW  = $clog2(START_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD       = 2'd1;
  localparam logic [1:0] WAIT_START = 2'd2;
  localparam logic [1:0] WAIT_DONE  = 2'd3;

  logic [1:0]         state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     grant;
  logic [7:0]         tx_byte;
  logic [TW-1:0]      timer;
  logic [IDW-1:0]     win;
  logic [7:0]         win_byte;
  logic               any_valid;
  logic [NUM_REQ-1:0] ready;
  int unsigned        scan_idx;
`ifdef UART_TX_ARB_TAG_EN
  logic               data_phase;
  logic [7:0]         data_byte;
`endif

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    win       = '0;
    win_byte  = '0;
    any_valid = 1'b0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = 32'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!any_valid && bus.req_valid[scan_idx]) begin
        any_valid = 1'b1;
        win       = IDW'(scan_idx);
        win_byte  = bus.req_data[8*scan_idx +: 8];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == IDLE && any_valid) ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IDW'(NUM_REQ - 1);
      grant      <= '0;
      tx_byte    <= '0;
      timer      <= '0;
`ifdef UART_TX_ARB_TAG_EN
      data_phase <= 1'b0;
      data_byte  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant <= win;
            ptr   <= win;
            state <= LOAD;
`ifdef UART_TX_ARB_TAG_EN
            tx_byte    <= {TAG_PREFIX, 4'(win)};
            data_byte  <= win_byte;
            data_phase <= 1'b0;
`else
            tx_byte <= win_byte;
`endif
          end
        end
        LOAD: begin
          timer <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.uart_is_transmitting) state <= WAIT_DONE;
          else if (timer == TIMER_LAST) state <= IDLE;
          else timer <= timer + TW'(1);
        end
        WAIT_DONE: begin
          if (!bus.uart_is_transmitting) begin
`ifdef UART_TX_ARB_TAG_EN
            // Tag frame done: send the held data byte without re-arbitrating.
            if (!data_phase) begin
              data_phase <= 1'b1;
              tx_byte    <= data_byte;
              state      <= LOAD;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.uart_transmit = (state == LOAD);
  assign bus.uart_tx_byte  = tx_byte;
  assign bus.grant_id      = grant;
  assign bus.busy          = (state != IDLE);
  assign bus.start_err     = (state == WAIT_START) && !bus.uart_is_transmitting &&
                             (timer == TIMER_LAST);
endmodule
